// File: rtl/fill_controller_pkg.sv
// Shared state codes, counter widths and output decode for the bottle fill controller.
package fill_controller_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned DB_CNT_W  = 8;
    localparam int unsigned TMO_CNT_W = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_MOVE  = 3'd1,
        ST_FILL  = 3'd2,
        ST_EXIT  = 3'd3,
        ST_FAULT = 3'd4
    } fill_state_e;

    typedef struct packed {
        logic conveyor_on;
        logic valve_open;
        logic bottle_done;
        logic fault;
        logic busy;
    } fill_outputs_t;

    // Output image for the state about to be entered; done flags the FILL->EXIT edge.
    function automatic fill_outputs_t decode_outputs(input fill_state_e nxt, input logic done);
        fill_outputs_t o;
        o.conveyor_on = (nxt == ST_MOVE) || (nxt == ST_EXIT);
        o.valve_open  = (nxt == ST_FILL);
        o.bottle_done = done;
        o.fault       = (nxt == ST_FAULT);
        o.busy        = (nxt != ST_IDLE);
        return o;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stable-run counter; clean flips only after
// CYCLES consecutive cycles of disagreement with the synchronized input.
module sensor_debounce
    import fill_controller_pkg::*;
#(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    logic                sync1_q;
    logic                sync2_q;
    logic [DB_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (sync2_q != clean) begin
                if (cnt_q == DB_CNT_W'(CYCLES - 1)) begin
                    clean <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + DB_CNT_W'(1);
                end
            end else begin
                // Any agreement breaks the run.
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/fill_controller.sv
// Bottling line sequencer: conveyor, bottle detect, timed fill, one-cycle done pulse.
// Outputs are registered from the next-state decode so they change with the state.
module fill_controller
    import fill_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FILL_TIMEOUT    = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               clear_fault,
    input  logic               bottle_raw,
    input  logic               level_raw,
    output logic               conveyor_on,
    output logic               valve_open,
    output logic               bottle_done,
    output logic               fault,
    output logic               busy,
    output logic [STATE_W-1:0] state
);

    fill_state_e          state_q;
    fill_state_e          state_d;
    logic [TMO_CNT_W-1:0] tmo_q;
    logic [TMO_CNT_W-1:0] tmo_d;
    logic                 stop_pending_q;
    logic                 stop_pending_d;
    fill_outputs_t        out_q;
    fill_outputs_t        out_d;
    logic                 bottle_db;
    logic                 level_db;
    logic                 timeout_hit_c;

    sensor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_bottle_db (
        .clk   (clk),
        .reset (reset),
        .raw   (bottle_raw),
        .clean (bottle_db)
    );

    sensor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_level_db (
        .clk   (clk),
        .reset (reset),
        .raw   (level_raw),
        .clean (level_db)
    );

    // Counter holds (cycles in FILL - 1), so the fault edge lands FILL_TIMEOUT edges after entry.
    assign timeout_hit_c = (tmo_q == TMO_CNT_W'(FILL_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            tmo_q          <= '0;
            stop_pending_q <= 1'b0;
            out_q          <= '0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            stop_pending_q <= stop_pending_d;
            out_q          <= out_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        tmo_d          = tmo_q;
        stop_pending_d = stop_pending_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) state_d = ST_MOVE;
            end
            ST_MOVE: begin
                if (stop)           state_d = ST_IDLE;
                else if (bottle_db) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (level_db)           state_d = ST_EXIT;
                else if (timeout_hit_c) state_d = ST_FAULT;
            end
            ST_EXIT: begin
                // A stop arriving on the leaving edge still counts.
                if (!bottle_db) state_d = (stop_pending_q || stop) ? ST_IDLE : ST_MOVE;
            end
            ST_FAULT: begin
                if (clear_fault) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q == ST_FILL || state_q == ST_EXIT) && stop) stop_pending_d = 1'b1;
        if (state_d == ST_IDLE)                                 stop_pending_d = 1'b0;

        if (state_d == ST_FILL && state_q != ST_FILL) tmo_d = '0;
        else if (state_q == ST_FILL)                  tmo_d = tmo_q + TMO_CNT_W'(1);

        out_d = decode_outputs(state_d, (state_q == ST_FILL) && (state_d == ST_EXIT));
    end

    assign conveyor_on = out_q.conveyor_on;
    assign valve_open  = out_q.valve_open;
    assign bottle_done = out_q.bottle_done;
    assign fault       = out_q.fault;
    assign busy        = out_q.busy;
    assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_fill_controller.sv
// Scoreboard bench for fill_controller: scenarios queue expected output changes
// with their cycle stamps; a negedge monitor compares each observed change.
module tb_fill_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear_fault = 1'b0;
    logic       bottle_raw = 1'b1;
    logic       level_raw = 1'b1;
    logic       conveyor_on;
    logic       valve_open;
    logic       bottle_done;
    logic       fault;
    logic       busy;
    logic [2:0] state;

    fill_controller #(.DEBOUNCE_CYCLES(4), .FILL_TIMEOUT(20)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .clear_fault (clear_fault),
        .bottle_raw  (bottle_raw),
        .level_raw   (level_raw),
        .conveyor_on (conveyor_on),
        .valve_open  (valve_open),
        .bottle_done (bottle_done),
        .fault       (fault),
        .busy        (busy),
        .state       (state)
    );

    always #5 clk = ~clk;

    // {state, conveyor_on, valve_open, bottle_done, fault, busy}
    localparam logic [7:0] V_IDLE  = 8'b000_00000;
    localparam logic [7:0] V_MOVE  = 8'b001_10001;
    localparam logic [7:0] V_FILL  = 8'b010_01001;
    localparam logic [7:0] V_EXITD = 8'b011_10101;
    localparam logic [7:0] V_EXIT  = 8'b011_10001;
    localparam logic [7:0] V_FAULT = 8'b100_00011;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  vec;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned base = 0;
    int unsigned total = 0;
    int unsigned bad = 0;
    logic        mon_en = 1'b0;
    logic [7:0]  prev = 8'h00;
    logic [7:0]  outv;

    assign outv = {state, conveyor_on, valve_open, bottle_done, fault, busy};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b required %b at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic expect_at(input int unsigned rel, input logic [7:0] vec, input string name);
        exp_t e;
        e.cyc  = base + rel;
        e.vec  = vec;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic new_base();
        @(negedge clk);
        base = cyc;
    endtask

    // Return at the negedge before relative edge n, so inputs set now are sampled at edge n.
    task automatic goto(input int unsigned n);
        while (cyc < base + n - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en && outv !== prev) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: got %b at cycle %0d, required no change from %b", outv, cyc, prev);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (outv !== e.vec || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d", e.name, outv, cyc, e.vec, e.cyc);
                end
            end
            prev = outv;
        end
    end

    initial begin
        // Reset held two edges with both sensors high.
        @(negedge clk);
        check("reset_edge1", outv, V_IDLE);
        @(negedge clk);
        check("reset_edge2", outv, V_IDLE);
        reset = 1'b0;
        bottle_raw = 1'b0;
        level_raw = 1'b0;
        @(negedge clk);
        check("reset_after", outv, V_IDLE);
        prev = V_IDLE;
        mon_en = 1'b1;
        repeat (10) @(negedge clk);

        // Normal bottle cycle.
        new_base();
        expect_at(1,  V_MOVE,  "normal_move");
        expect_at(16, V_FILL,  "normal_fill");
        expect_at(26, V_EXITD, "normal_exit_done");
        expect_at(27, V_EXIT,  "normal_done_drop");
        expect_at(36, V_MOVE,  "normal_back_to_move");
        start = 1'b1;
        goto(2);  start = 1'b0;
        goto(10); bottle_raw = 1'b1;
        goto(20); level_raw = 1'b1;
        goto(30); bottle_raw = 1'b0; level_raw = 1'b0;
        goto(42);

        // Three-cycle bottle glitch while in MOVE must be rejected.
        new_base();
        goto(1);  bottle_raw = 1'b1;
        goto(4);  bottle_raw = 1'b0;
        goto(20);
        check("glitch_state_move", outv, V_MOVE);

        // Fill timeout into FAULT, then clear.
        new_base();
        expect_at(7,  V_FILL,  "timeout_fill");
        expect_at(27, V_FAULT, "timeout_fault");
        expect_at(30, V_IDLE,  "fault_cleared");
        goto(1);  bottle_raw = 1'b1;
        goto(10); start = 1'b1;
        goto(12); start = 1'b0;
        goto(30); clear_fault = 1'b1; bottle_raw = 1'b0;
        goto(31); clear_fault = 1'b0;
        goto(40);

        // Stop during FILL: bottle completes, then IDLE.
        new_base();
        expect_at(1,  V_MOVE,  "stop_move");
        expect_at(8,  V_FILL,  "stop_fill");
        expect_at(18, V_EXITD, "stop_exit_done");
        expect_at(19, V_EXIT,  "stop_done_drop");
        expect_at(26, V_IDLE,  "stop_to_idle");
        start = 1'b1;
        goto(2);  start = 1'b0; bottle_raw = 1'b1;
        goto(10); stop = 1'b1;
        goto(11); stop = 1'b0;
        goto(12); level_raw = 1'b1;
        goto(20); bottle_raw = 1'b0; level_raw = 1'b0;
        goto(34);

        // start and stop together in IDLE: stop wins.
        new_base();
        start = 1'b1; stop = 1'b1;
        goto(4);
        check("start_stop_idle", outv, V_IDLE);
        start = 1'b0; stop = 1'b0;
        goto(10);

        // Reset while the valve is open.
        new_base();
        expect_at(1,  V_MOVE, "rst_move");
        expect_at(8,  V_FILL, "rst_fill");
        expect_at(12, V_IDLE, "rst_mid_fill");
        start = 1'b1;
        goto(2);  start = 1'b0; bottle_raw = 1'b1;
        goto(12); reset = 1'b1;
        goto(13); reset = 1'b0; bottle_raw = 1'b0;
        check("rst_valve_closed", outv, V_IDLE);
        goto(25);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_expectations: got %0d left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
